// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared encodings for the CPU SRAM-like bus masters and arbiters
package cpu_bus_pkg;

  // Arbiter FSM: wait for a request, present the address, wait for the data phase.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  // Master identifiers, also the encoding of the grant output.
  localparam logic M_INST = 1'b0;
  localparam logic M_DATA = 1'b1;

  // Transfer size codes carried on *_size.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/arb_pick2.sv
// rtl/arb_pick2.sv - two-master winner selection, fixed data priority or round-robin
module arb_pick2
  import cpu_bus_pkg::*;
#(
  parameter bit PRIO_DATA = 1'b1
) (
  input  logic inst_req,
  input  logic data_req,
  input  logic last_grant,
  output logic any_req,
  output logic winner
);

  // Contention goes to data (fixed) or to whoever did not win last; a lone request always wins.
  always_comb begin
    any_req = inst_req | data_req;
    winner  = M_INST;
    if (inst_req && data_req) begin
      if (PRIO_DATA) begin
        winner = M_DATA;
      end else begin
        winner = ~last_grant;
      end
    end else if (data_req) begin
      winner = M_DATA;
    end
  end

endmodule

// File: rtl/sramlike_mem_arbiter.sv
// rtl/sramlike_mem_arbiter.sv - shares one SRAM-like memory port between inst and data masters
module sramlike_mem_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter bit PRIO_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              grant,
  output logic              busy
);

  arb_state_t state, state_d;
  logic       grant_q, grant_d;
  logic       last_grant, last_grant_d;
  logic       any_req;
  logic       pick;
  logic       resp_route;
  logic       resp_ok;

  arb_pick2 #(
    .PRIO_DATA (PRIO_DATA)
  ) u_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .last_grant (last_grant),
    .any_req    (any_req),
    .winner     (pick)
  );

  // State, owner and fairness history; reset returns the port to idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_q    <= M_INST;
      last_grant <= M_INST;
    end else begin
      state      <= state_d;
      grant_q    <= grant_d;
      last_grant <= last_grant_d;
    end
  end

  // Next state plus all bus outputs; the granted master's live fields drive memory in ADDR.
  always_comb begin
    state_d      = state;
    grant_d      = grant_q;
    last_grant_d = last_grant;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = 2'd0;
    mem_addr     = '0;
    mem_wdata    = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;
    resp_route   = 1'b0;
    resp_ok      = 1'b0;

    case (state)
      IDLE: begin
        // Any mem_data_ok seen here is spurious and simply dropped.
        if (any_req) begin
          grant_d = pick;
          state_d = ADDR;
        end
      end

      ADDR: begin
        mem_req = 1'b1;
        if (grant_q == M_DATA) begin
          mem_wr       = data_wr;
          mem_size     = data_size;
          mem_addr     = data_addr;
          mem_wdata    = data_wdata;
          data_addr_ok = mem_addr_ok;
        end else begin
          mem_wr       = inst_wr;
          mem_size     = inst_size;
          mem_addr     = inst_addr;
          mem_wdata    = inst_wdata;
          inst_addr_ok = mem_addr_ok;
        end
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            // Memory finished both phases in one cycle: complete without visiting DATA.
            resp_route   = 1'b1;
            resp_ok      = 1'b1;
            last_grant_d = grant_q;
            state_d      = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        resp_route = 1'b1;
        resp_ok    = mem_data_ok;
        if (mem_data_ok) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Response path only ever reaches the owner; the other master sees zeros.
    if (resp_route) begin
      if (grant_q == M_DATA) begin
        data_data_ok = resp_ok;
        data_rdata   = mem_rdata;
      end else begin
        inst_data_ok = resp_ok;
        inst_rdata   = mem_rdata;
      end
    end
  end

  assign grant = grant_q;
  assign busy  = (state != IDLE);

endmodule
